hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Pipeline hazard and stall sequencer for the 5-stage CPU. Sits beside the operand-forwarding logic.
//   Resolves what forwarding cannot: load-use bubbles, taken-branch and jump flushes, the multi-cycle
//   mul/div handshake and data-memory wait states.
//   Drives the write-enables and flushes of the PC and all pipeline registers.
// PARAMETERS
//   REG_AW      5    register address width
//   MD_TIMEOUT  64   max MD_WAIT cycles before watchdog abort (>=2)
//   CNT_W       32   perf counter width (only with HAZARD_PERF_CNT_EN)
// PORTS
//   clk           in   1       core clock
//   reset         in   1       asynchronous, active-high reset
//   ID_RegRs      in   REG_AW  rs of instruction in ID
//   ID_RegRt      in   REG_AW  rt of instruction in ID
//   ID_UsesRt     in   1       ID instruction reads rt as an ALU operand
//   ID_MemWrite   in   1       ID instruction is a store (rt is store data only)
//   ID_Jump       in   1       jump resolved in ID
//   ID_MulDivReq  in   1       ID instruction needs the mul/div unit
//   EX_MemRead    in   1       EX instruction is a load
//   EX_RegWrAddr  in   REG_AW  destination of EX instruction
//   EX_BranchTaken in  1       branch resolved taken in EX
//   MEM_Access    in   1       MEM-stage instruction accesses data memory
//   MEM_Ready     in   1       data memory completes access this cycle
//   MD_Done       in   1       mul/div result valid (1-cycle pulse)
//   PC_Write      out  1       PC update enable
//   IF_ID_Write   out  1       IF/ID hold when 0
//   IF_ID_Flush   out  1       IF/ID -> NOP
//   ID_EX_Write   out  1       ID/EX hold when 0
//   ID_EX_Flush   out  1       ID/EX -> bubble
//   EX_MEM_Write  out  1       EX/MEM hold when 0
//   MEM_WB_Flush  out  1       MEM/WB -> bubble
//   MD_Start      out  1       1-cycle start pulse to mul/div unit
//   MD_Error      out  1       sticky watchdog abort flag
//   Ctrl_State    out  1       0 = RUN, 1 = MD_WAIT
// BEHAVIOUR
//   - Reset: state RUN, wd counter 0, MD_Error 0, counters 0.
//     Outputs during/after reset: all *_Write 1, all flushes 0, MD_Start 0.
//   - LoadUse = EX_MemRead & EX_RegWrAddr!=0 & (Rs match | (Rt match & ID_UsesRt & !ID_MemWrite)).
//     A lw->sw data dependency is covered by MEM-stage store forwarding, so it never stalls.
//   - MemWait = MEM_Access & !MEM_Ready. Freeze overlay in any state:
//     PC/IF_ID/ID_EX/EX_MEM Write=0, MEM_WB_Flush=1.
//     All other actions are suppressed that cycle. FSM state and wd counter hold.
//   - Priority when !MemWait: BranchTaken > MD_WAIT stall > MulDiv start > LoadUse > Jump.
//   - BranchTaken: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
//     Cancels any same-cycle MulDivReq/LoadUse/Jump action, since the ID instruction is killed.
//   - RUN & ID_MulDivReq: MD_Start=1 for exactly one cycle, PC/IF_ID hold, ID_EX_Flush=1 -> MD_WAIT.
//   - MD_WAIT: PC/IF_ID hold, ID_EX_Flush=1 each cycle, wd counter +1.
//     MD_Done: release that cycle (all Write=1, no flush), go to RUN, wd counter clears.
//     wd counter reaching MD_TIMEOUT-1 without MD_Done: MD_Error<=1, go to RUN.
//     The ID instruction then proceeds with undefined result.
//   - MD_Done seen in RUN is ignored.
//   - BranchTaken in MD_WAIT cannot occur (EX holds a bubble); the FSM ignores it.
//   - LoadUse: exactly one bubble (PC/IF_ID hold, ID_EX_Flush=1).
//     The next cycle the load is in MEM and forwarding resolves the dependency.
//   - Jump (no higher event): IF_ID_Flush=1 only.
//   - Outputs are combinational from state + inputs. Only state, wd counter, MD_Error and counters
//     are registered. Async reset mid-MD_WAIT returns to RUN immediately, with no MD_Start.
// CONFIGURATION
//   HAZARD_PERF_CNT_EN defined: adds outputs
//     Perf_StallCycles[CNT_W] (cycles with PC_Write=0)
//     Perf_FlushCount[CNT_W] (cycles with IF_ID_Flush|ID_EX_Flush)
//   Counters saturate at all-ones and are cleared by reset.
//   Undefined: those ports and registers are absent; behaviour is otherwise identical.
// STRUCTURE
//   hazard_pkg: state encoding (ST_RUN, ST_MD_WAIT), REG_AW default, priority comments, NOP constants.
//   Sub-module hazard_perf_counters: two saturating counters under the macro.
//   The FSM and priority logic stay in this module.
// TESTING
//   lw $8 in EX, add rs=$8 in ID -> 1 cycle PC_Write=0, ID_EX_Flush=1; next cycle all Write=1.
//   lw $8 in EX, sw rt=$8 in ID (ID_MemWrite=1) -> no stall.
//   MulDivReq, MD_Done after 5 cycles -> MD_Start one pulse, 6 stall cycles, release on the Done cycle.
//   Same-cycle MulDivReq and EX_BranchTaken -> flush both, MD_Start=0, state RUN.
//   MemWait during MD_WAIT -> full freeze, wd holds; MD_Done while MemWait is ignored until MEM_Ready.
//   MD_TIMEOUT=4, no MD_Done -> MD_Error=1 after 4 wait cycles, RUN; reset clears MD_Error.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer: FSM encoding,
// default widths, and the pipeline NOP constants used when a stage is flushed.
package hazard_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } ctrl_state_e;

    localparam int REG_AW_DEF = 5;

    // Flushed IF/ID holds an all-zero word (sll $0,$0,0); a bubble clears all control bits.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic        NOP_CTRL  = 1'b0;

    // Action priority when memory is not stalling:
    //   EX_BranchTaken > MD_WAIT stall > mul/div start > load-use bubble > jump.
    // A data-memory wait state overrides everything and freezes the pipeline.

endpackage

// File: rtl/hazard_perf_counters.sv
// Two saturating event counters: stall cycles and flush cycles.
// Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallEvt,
    input  logic             flushEvt,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (stallEvt && (stallCycles != {CNT_W{1'b1}}))
                stallCycles <= stallCycles + 1'b1;
            if (flushEvt && (flushCount != {CNT_W{1'b1}}))
                flushCount <= flushCount + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall sequencer: load-use bubbles, branch/jump flushes,
// mul/div handshake with watchdog, and data-memory freeze. Option: HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int MD_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ID_RegRs,
    input  logic [REG_AW-1:0] ID_RegRt,
    input  logic              ID_UsesRt,
    input  logic              ID_MemWrite,
    input  logic              ID_Jump,
    input  logic              ID_MulDivReq,
    input  logic              EX_MemRead,
    input  logic [REG_AW-1:0] EX_RegWrAddr,
    input  logic              EX_BranchTaken,
    input  logic              MEM_Access,
    input  logic              MEM_Ready,
    input  logic              MD_Done,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Write,
    output logic              ID_EX_Flush,
    output logic              EX_MEM_Write,
    output logic              MEM_WB_Flush,
    output logic              MD_Start,
    output logic              MD_Error,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  Perf_StallCycles,
    output logic [CNT_W-1:0]  Perf_FlushCount,
`endif
    output logic              Ctrl_State
);

    localparam int              WD_W    = $clog2(MD_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    ctrl_state_e     state, stateNext;
    logic [WD_W-1:0] wdCnt, wdNext;
    logic            errSet;
    logic            memWait;
    logic            loadUse;

    assign memWait = MEM_Access & ~MEM_Ready;

    // A store's rt is data only; MEM-stage store forwarding covers lw->sw.
    assign loadUse = EX_MemRead && (EX_RegWrAddr != '0) &&
                     ((EX_RegWrAddr == ID_RegRs) ||
                      ((EX_RegWrAddr == ID_RegRt) && ID_UsesRt && !ID_MemWrite));

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;
        MEM_WB_Flush = 1'b0;
        MD_Start     = 1'b0;
        stateNext    = state;
        wdNext       = wdCnt;
        errSet       = 1'b0;

        if (reset) begin
            // Outputs stay at pass-through values while reset is held.
        end else if (memWait) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (state == ST_MD_WAIT) begin
            // EX holds a bubble here, so a taken branch cannot occur and is not decoded.
            if (MD_Done) begin
                stateNext = ST_RUN;
                wdNext    = '0;
            end else if (wdCnt == WD_LAST) begin
                // Watchdog abort releases the held instruction so it cannot re-issue.
                errSet    = 1'b1;
                stateNext = ST_RUN;
                wdNext    = '0;
            end else begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
                wdNext      = wdCnt + 1'b1;
            end
        end else if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (ID_MulDivReq) begin
            MD_Start    = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            stateNext   = ST_MD_WAIT;
            wdNext      = '0;
        end else if (loadUse) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            wdCnt    <= '0;
            MD_Error <= 1'b0;
        end else begin
            state <= stateNext;
            wdCnt <= wdNext;
            if (errSet)
                MD_Error <= 1'b1;
        end
    end

    assign Ctrl_State = (state == ST_MD_WAIT);

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (clk),
        .reset       (reset),
        .stallEvt    (~PC_Write),
        .flushEvt    (IF_ID_Flush | ID_EX_Flush),
        .stallCycles (Perf_StallCycles),
        .flushCount  (Perf_FlushCount)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one instance with the default watchdog
// and one with MD_TIMEOUT=4, both driven from the same inputs.
module tb_hazard_stall_ctrl;

  // Control vector order: PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, MEMWB_F, MD_Start
  localparam logic [7:0] V_NORMAL = 8'b1101_0100;
  localparam logic [7:0] V_STALL  = 8'b0001_1100;
  localparam logic [7:0] V_MDST   = 8'b0001_1101;
  localparam logic [7:0] V_BRANCH = 8'b1111_1100;
  localparam logic [7:0] V_JUMP   = 8'b1111_0100;
  localparam logic [7:0] V_FREEZE = 8'b0000_0010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] ID_RegRs, ID_RegRt, EX_RegWrAddr;
  logic       ID_UsesRt, ID_MemWrite, ID_Jump, ID_MulDivReq;
  logic       EX_MemRead, EX_BranchTaken, MEM_Access, MEM_Ready, MD_Done;

  logic pcW, ifidW, ifidF, idexW, idexF, exmemW, memwbF, mdStart, mdErr, ctrlState;
  logic pcWT, ifidWT, ifidFT, idexWT, idexFT, exmemWT, memwbFT, mdStartT, mdErrT, ctrlStateT;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perfStall, perfFlush, perfStallT, perfFlushT;
`endif

  logic [7:0] ctrlVec, ctrlVecTo;
  assign ctrlVec   = {pcW, ifidW, ifidF, idexW, idexF, exmemW, memwbF, mdStart};
  assign ctrlVecTo = {pcWT, ifidWT, ifidFT, idexWT, idexFT, exmemWT, memwbFT, mdStartT};

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_UsesRt(ID_UsesRt),
    .ID_MemWrite(ID_MemWrite), .ID_Jump(ID_Jump), .ID_MulDivReq(ID_MulDivReq),
    .EX_MemRead(EX_MemRead), .EX_RegWrAddr(EX_RegWrAddr), .EX_BranchTaken(EX_BranchTaken),
    .MEM_Access(MEM_Access), .MEM_Ready(MEM_Ready), .MD_Done(MD_Done),
    .PC_Write(pcW), .IF_ID_Write(ifidW), .IF_ID_Flush(ifidF), .ID_EX_Write(idexW),
    .ID_EX_Flush(idexF), .EX_MEM_Write(exmemW), .MEM_WB_Flush(memwbF),
    .MD_Start(mdStart), .MD_Error(mdErr),
`ifdef HAZARD_PERF_CNT_EN
    .Perf_StallCycles(perfStall), .Perf_FlushCount(perfFlush),
`endif
    .Ctrl_State(ctrlState)
  );

  hazard_stall_ctrl #(.MD_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_UsesRt(ID_UsesRt),
    .ID_MemWrite(ID_MemWrite), .ID_Jump(ID_Jump), .ID_MulDivReq(ID_MulDivReq),
    .EX_MemRead(EX_MemRead), .EX_RegWrAddr(EX_RegWrAddr), .EX_BranchTaken(EX_BranchTaken),
    .MEM_Access(MEM_Access), .MEM_Ready(MEM_Ready), .MD_Done(MD_Done),
    .PC_Write(pcWT), .IF_ID_Write(ifidWT), .IF_ID_Flush(ifidFT), .ID_EX_Write(idexWT),
    .ID_EX_Flush(idexFT), .EX_MEM_Write(exmemWT), .MEM_WB_Flush(memwbFT),
    .MD_Start(mdStartT), .MD_Error(mdErrT),
`ifdef HAZARD_PERF_CNT_EN
    .Perf_StallCycles(perfStallT), .Perf_FlushCount(perfFlushT),
`endif
    .Ctrl_State(ctrlStateT)
  );

  task automatic set_idle();
    ID_RegRs = 5'd0; ID_RegRt = 5'd0; EX_RegWrAddr = 5'd0;
    ID_UsesRt = 1'b0; ID_MemWrite = 1'b0; ID_Jump = 1'b0; ID_MulDivReq = 1'b0;
    EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
    MEM_Access = 1'b0; MEM_Ready = 1'b1; MD_Done = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // Hazard-looking inputs must not leak through while reset is held.
    set_idle();
    ID_MulDivReq = 1'b1; EX_MemRead = 1'b1; EX_RegWrAddr = 5'd8; ID_RegRs = 5'd8;
    reset = 1'b1;
    #2;
    total++;
    if (ctrlVec !== V_NORMAL) begin bad++; $display("FAIL reset_ctrl: got %b want %b", ctrlVec, V_NORMAL); end
    step();
    total++;
    if (ctrlState !== 1'b0 || mdErr !== 1'b0) begin
      bad++; $display("FAIL reset_state: state=%b err=%b want 0 0", ctrlState, mdErr);
    end
    set_idle();
    reset = 1'b0;
    #1;
    total++;
    if (ctrlVec !== V_NORMAL) begin bad++; $display("FAIL post_reset_ctrl: got %b want %b", ctrlVec, V_NORMAL); end
    step();
  endtask

  task automatic test_load_use();
    int rsT [6];
    int rtT [6];
    logic usesT [6];
    logic mwT [6];
    logic rdT [6];
    int dstT [6];
    logic [7:0] expT [6];
    rsT   = '{8, 3, 3, 3, 0, 8};
    rtT   = '{3, 8, 8, 8, 0, 8};
    usesT = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    mwT   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rdT   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dstT  = '{8, 8, 8, 8, 0, 8};
    expT  = '{V_STALL, V_STALL, V_NORMAL, V_NORMAL, V_NORMAL, V_NORMAL};
    for (int i = 0; i < 6; i++) begin
      set_idle();
      ID_RegRs = 5'(rsT[i]); ID_RegRt = 5'(rtT[i]); ID_UsesRt = usesT[i];
      ID_MemWrite = mwT[i]; EX_MemRead = rdT[i]; EX_RegWrAddr = 5'(dstT[i]);
      #1;
      total++;
      if (ctrlVec !== expT[i]) begin bad++; $display("FAIL load_use_%0d: got %b want %b", i, ctrlVec, expT[i]); end
      step();
      // Next cycle the bubble sits in EX; the same ID instruction must now proceed.
      EX_MemRead = 1'b0; EX_RegWrAddr = 5'd0;
      #1;
      total++;
      if (ctrlVec !== V_NORMAL) begin bad++; $display("FAIL load_use_after_%0d: got %b want %b", i, ctrlVec, V_NORMAL); end
      step();
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    ID_MulDivReq = 1'b1; EX_BranchTaken = 1'b1; ID_Jump = 1'b1;
    EX_MemRead = 1'b1; EX_RegWrAddr = 5'd8; ID_RegRs = 5'd8;
    #1;
    total++;
    if (ctrlVec !== V_BRANCH) begin bad++; $display("FAIL branch_cancel: got %b want %b", ctrlVec, V_BRANCH); end
    step();
    set_idle();
    #1;
    total++;
    if (ctrlState !== 1'b0 || ctrlVec !== V_NORMAL) begin
      bad++; $display("FAIL branch_cancel_after: state=%b ctrl=%b want 0 %b", ctrlState, ctrlVec, V_NORMAL);
    end
    step();
    ID_Jump = 1'b1;
    #1;
    total++;
    if (ctrlVec !== V_JUMP) begin bad++; $display("FAIL jump: got %b want %b", ctrlVec, V_JUMP); end
    EX_MemRead = 1'b1; EX_RegWrAddr = 5'd9; ID_RegRt = 5'd9; ID_UsesRt = 1'b1;
    #1;
    total++;
    if (ctrlVec !== V_STALL) begin bad++; $display("FAIL jump_vs_load_use: got %b want %b", ctrlVec, V_STALL); end
    EX_BranchTaken = 1'b1; MEM_Access = 1'b1; MEM_Ready = 1'b0;
    #1;
    total++;
    if (ctrlVec !== V_FREEZE) begin bad++; $display("FAIL freeze_over_branch: got %b want %b", ctrlVec, V_FREEZE); end
    step();
    set_idle();
  endtask

  task automatic test_muldiv();
    int stalls;
    do_reset();
    stalls = 0;
    ID_MulDivReq = 1'b1;
    #1;
    total++;
    if (ctrlVec !== V_MDST) begin bad++; $display("FAIL md_start: got %b want %b", ctrlVec, V_MDST); end
    if (pcW === 1'b0) stalls++;
    step();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ctrlVec !== V_STALL || ctrlState !== 1'b1) begin
        bad++; $display("FAIL md_wait_%0d: ctrl=%b state=%b want %b 1", i, ctrlVec, ctrlState, V_STALL);
      end
      if (pcW === 1'b0) stalls++;
      step();
    end
    MD_Done = 1'b1;
    #1;
    total++;
    if (ctrlVec !== V_NORMAL) begin bad++; $display("FAIL md_release: got %b want %b", ctrlVec, V_NORMAL); end
    total++;
    if (stalls !== 6) begin bad++; $display("FAIL md_stall_count: got %0d want 6", stalls); end
    step();
    set_idle();
    #1;
    total++;
    if (ctrlState !== 1'b0 || mdErr !== 1'b0) begin
      bad++; $display("FAIL md_back_to_run: state=%b err=%b want 0 0", ctrlState, mdErr);
    end
    MD_Done = 1'b1;
    #1;
    total++;
    if (ctrlVec !== V_NORMAL) begin bad++; $display("FAIL md_done_in_run: got %b want %b", ctrlVec, V_NORMAL); end
    step();
    set_idle();
    total++;
    if (ctrlState !== 1'b0) begin bad++; $display("FAIL md_done_in_run_state: got %b want 0", ctrlState); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    ID_MulDivReq = 1'b1;
    step();
    step();
    step();
    // dut_to watchdog now at 2 of 3; a frozen cycle must not advance it.
    MEM_Access = 1'b1; MEM_Ready = 1'b0; MD_Done = 1'b1;
    #1;
    total++;
    if (ctrlVecTo !== V_FREEZE) begin bad++; $display("FAIL mw_freeze: got %b want %b", ctrlVecTo, V_FREEZE); end
    step();
    total++;
    if (ctrlStateT !== 1'b1) begin bad++; $display("FAIL mw_state_hold: got %b want 1", ctrlStateT); end
    MEM_Access = 1'b0; MEM_Ready = 1'b1; MD_Done = 1'b0;
    #1;
    total++;
    if (ctrlVecTo !== V_STALL) begin bad++; $display("FAIL mw_wd_hold: got %b want %b", ctrlVecTo, V_STALL); end
    step();
    MEM_Access = 1'b1; MEM_Ready = 1'b0; MD_Done = 1'b1;
    step();
    step();
    MEM_Ready = 1'b1;
    #1;
    total++;
    if (ctrlVecTo !== V_NORMAL) begin bad++; $display("FAIL mw_release: got %b want %b", ctrlVecTo, V_NORMAL); end
    step();
    set_idle();
    total++;
    if (ctrlStateT !== 1'b0 || mdErrT !== 1'b0) begin
      bad++; $display("FAIL mw_after: state=%b err=%b want 0 0", ctrlStateT, mdErrT);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ID_MulDivReq = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ctrlVecTo !== V_STALL || ctrlStateT !== 1'b1 || mdErrT !== 1'b0) begin
        bad++; $display("FAIL to_wait_%0d: ctrl=%b state=%b err=%b want %b 1 0", i, ctrlVecTo, ctrlStateT, mdErrT, V_STALL);
      end
      step();
    end
    total++;
    if (ctrlVecTo !== V_NORMAL || ctrlStateT !== 1'b1) begin
      bad++; $display("FAIL to_abort: ctrl=%b state=%b want %b 1", ctrlVecTo, ctrlStateT, V_NORMAL);
    end
    step();
    ID_MulDivReq = 1'b0;
    #1;
    total++;
    if (ctrlStateT !== 1'b0 || mdErrT !== 1'b1) begin
      bad++; $display("FAIL to_error: state=%b err=%b want 0 1", ctrlStateT, mdErrT);
    end
    step();
    total++;
    if (mdErrT !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", mdErrT); end
    do_reset();
    total++;
    if (mdErrT !== 1'b0) begin bad++; $display("FAIL to_reset_clear: got %b want 0", mdErrT); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ID_MulDivReq = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (ctrlState !== 1'b0 || ctrlVec !== V_NORMAL) begin
      bad++; $display("FAIL reset_mid_wait: state=%b ctrl=%b want 0 %b", ctrlState, ctrlVec, V_NORMAL);
    end
    step();
    set_idle();
    reset = 1'b0;
    step();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_branch_jump();
    test_muldiv();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
